mux_rr_arbiter: RTL
===================

# mux_rr_arbiter

Round-robin arbiter that shares the 8-to-1 multiplexer datapath among eight requesters. It grants one requester at a time, drives the 3-bit mux select, and registers the selected input bit onto a single output. Grant tenure is bounded by a hold limit. The block sits between the requesting sources and the downstream consumer of the multiplexed bit.

## Interface
- HOLD_MAX, default 4: maximum consecutive grant cycles per tenure; legal range 1..15.
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- req  input  [7:0]  request per source; level-sensitive, held by the source while it wants the mux.
- in  input  [7:0]  data bit per source; in[k] belongs to source k.
- grant  output  [7:0]  one-hot grant, registered; all-zero when idle.
- sel  output  [2:0]  binary index of the granted source, registered; drives the mux select.
- busy  output  1  high while any grant is active; equals |grant.
- out  output  1  registered copy of in[sel] while granted; 0 otherwise.
- out_valid  output  1  high on cycles where out carries granted data.

## Operation
- States: IDLE (no grant) and GRANT (exactly one grant bit high).
- Reset values: grant=8'h00, sel=3'd0, busy=0, out=0, out_valid=0, hold count=0, last pointer=3'd7. With last=7, source 0 has highest priority after reset.
- Arbitration search runs in index order last+1, last+2, … modulo 8. The first asserted req wins. The search wraps from 7 to 0.
- IDLE: if req != 0 at a rising edge, grant the winner at that edge. Set sel=winner, last=winner, count=1, state=GRANT. If req == 0, stay in IDLE.
- GRANT, at each rising edge:
  - If req[sel]=1 and count<HOLD_MAX: keep the grant and increment count.
  - Otherwise the tenure ends. If req != 0, re-arbitrate at the same edge with no idle bubble. The new winner is loaded with count=1 and last=winner. If req == 0, clear grant and go to IDLE.
  - Because the search starts at sel+1, the outgoing holder has lowest priority. If it is the only requester, it is re-granted for a fresh tenure.
- Data path:
  - Each edge: out <= in[sel] and out_valid <= 1 if state was GRANT before the edge; otherwise out <= 0 and out_valid <= 0.
  - out always reflects the source that held the grant in the preceding cycle.
- Invariants: grant is always one-hot or zero. sel equals the index of grant's set bit whenever busy=1. sel holds its last value while idle.
- reset asserted mid-tenure: all outputs take reset values asynchronously, with no completion of the tenure. After deassertion, arbitration restarts from source 0 priority.

## Timing
- Request to grant: req sampled high at edge t gives grant/sel/busy high after edge t. Latency is 1 edge from the first edge where req is seen.
- Grant to data: in[sel] during the grant cycle appears on out after the next edge. out_valid rises one cycle after busy.
- Tenure length: at most HOLD_MAX grant cycles. A source that drops req after k cycles (k<HOLD_MAX) loses the grant at the first edge where req[sel]=0 is sampled.
- Handover: with another request pending, grant moves between sources in one edge. busy stays high and there are no idle cycles.
- Fairness: with all 8 sources requesting continuously, each source is granted once per 8·HOLD_MAX cycles, in ascending index order with wrap.
- Simultaneous req rise on several sources: only the search-order winner is granted. The others wait; no request is lost while held.

## Test plan
- Reset, then req=8'h01 held and in[0]=1: grant=8'h01 and sel=0 one edge after req is seen. out=1 and out_valid=1 one edge later. With HOLD_MAX=4 and only source 0 requesting, it is re-granted continuously with no gap.
- req=8'hFF held, HOLD_MAX=4: grant sequence is 0,1,…,7,0, with each source granted for exactly 4 consecutive cycles. busy never drops.
- Source 5 granted, req[5] drops after 2 cycles while req=8'h09 is pending: the next edge grants source 0 (wrap past 7), not source 3.
- Wrap: last=6 and req=8'h41: source 0 wins over source 6, because 6 now has lowest priority.
- All req dropped mid-tenure: grant=0, busy=0, sel held at its last value. out_valid=0 from the following edge on, with out=0.
- reset pulsed during a tenure with req=8'h80 held: outputs clear asynchronously. After release, source 7 is granted one edge after the first sampled edge.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//
// Round-robin arbiter that shares an 8-to-1 multiplexer among eight
// requesters. It grants one source at a time, drives the mux select, and
// registers the selected data bit onto a single output. A single tenure lasts
// at most HOLD_MAX consecutive grant cycles. After that, the arbiter searches
// again starting just past the outgoing holder.
//
// Parameters
//   HOLD_MAX     maximum consecutive grant cycles per tenure (1..15)
//
// Ports
//   clk_i        clock; all state updates on the rising edge
//   reset_i      asynchronous active-high reset
//   req_i[7:0]   level-sensitive request per source
//   in_i[7:0]    data bit per source, in_i[k] belongs to source k
//   grant_o[7:0] registered one-hot grant, zero when idle
//   sel_o[2:0]   registered binary index of the granted source
//   busy_o       high while any grant is active (|grant_o)
//   out_o        registered copy of in_i[sel] from the previous grant cycle
//   out_valid_o  high when out_o carries granted data
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] req_i,
    input  logic [7:0] in_i,
    output logic [7:0] grant_o,
    output logic [2:0] sel_o,
    output logic       busy_o,
    output logic       out_o,
    output logic       out_valid_o
);

    localparam logic [3:0] HOLD_CAP = 4'(HOLD_MAX);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] last_q, last_d;
    logic [3:0] holdCnt_q, holdCnt_d;
    logic       out_q, out_d;
    logic       outValid_q, outValid_d;

    logic [2:0] winIdx;
    logic [2:0] candIdx;

    // Round-robin search starting at last_q+1.
    // Candidates are scanned from the lowest priority (last_q itself, offset 8)
    // up to the highest (offset 1). The final hit therefore belongs to the
    // highest-priority requester. The 3-bit addition gives the wrap from 7
    // to 0 for free.
    always_comb begin
        winIdx  = last_q;
        candIdx = last_q;
        for (int i = 8; i >= 1; i--) begin
            candIdx = last_q + 3'(i);
            if (req_i[candIdx]) begin
                winIdx = candIdx;
            end
        end
    end

    // Next-state logic.
    // The holder keeps the grant while it still requests and has tenure
    // budget left. Otherwise a new winner is loaded at the same edge, so the
    // handover has no idle bubble. The arbiter goes idle only when nobody
    // requests.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        last_d    = last_q;
        holdCnt_d = holdCnt_q;

        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d   = GRANT;
                    grant_d   = 8'd1 << winIdx;
                    sel_d     = winIdx;
                    last_d    = winIdx;
                    holdCnt_d = 4'd1;
                end
            end
            GRANT: begin
                if (req_i[sel_q] && (holdCnt_q < HOLD_CAP)) begin
                    holdCnt_d = holdCnt_q + 4'd1;
                end else if (|req_i) begin
                    grant_d   = 8'd1 << winIdx;
                    sel_d     = winIdx;
                    last_d    = winIdx;
                    holdCnt_d = 4'd1;
                end else begin
                    state_d   = IDLE;
                    grant_d   = 8'd0;
                    holdCnt_d = 4'd0;
                end
            end
            default: begin
                state_d   = IDLE;
                grant_d   = 8'd0;
                holdCnt_d = 4'd0;
            end
        endcase
    end

    // Data path.
    // The output captures the bit of whichever source held the grant during
    // the cycle now ending. It is forced to zero when nobody held the grant.
    always_comb begin
        out_d      = 1'b0;
        outValid_d = 1'b0;
        if (state_q == GRANT) begin
            out_d      = in_i[sel_q];
            outValid_d = 1'b1;
        end
    end

    // State register.
    // last_q resets to 7 so that source 0 has first priority after reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            grant_q    <= 8'd0;
            sel_q      <= 3'd0;
            last_q     <= 3'd7;
            holdCnt_q  <= 4'd0;
            out_q      <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            holdCnt_q  <= holdCnt_d;
            out_q      <= out_d;
            outValid_q <= outValid_d;
        end
    end

    assign grant_o     = grant_q;
    assign sel_o       = sel_q;
    assign busy_o      = |grant_q;
    assign out_o       = out_q;
    assign out_valid_o = outValid_q;

endmodule
